issue_queue_dispatch: RTL and testbench
=======================================

ISSUE_QUEUE_DISPATCH -- requirements
Module: issue_queue_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter NR_FU, default 4, number of functional-unit channels (>=1).
REQ-003 SHALL have parameter DATA_W, default 64, operand width.
REQ-004 SHALL have parameter TID_W, default 3, transaction-id width.
REQ-005 SHALL derive FU_IDX_W = max(1,clog2(NR_FU)+1) and CNT_W = clog2(DEPTH)+1.
REQ-006 clk_i  in  1  single clock, all state on rising edge.
REQ-007 rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 flush_i  in  1  discard all queued, unissued entries.
REQ-009 instr_valid_i / instr_ready_o  in/out  1/1  push handshake.
REQ-010 instr_fu_i  in  FU_IDX_W  target FU index.
REQ-011 instr_tid_i  in  TID_W  scoreboard transaction id.
REQ-012 instr_op_a_i, instr_op_b_i  in  DATA_W each  operands.
REQ-013 fu_valid_o / fu_ready_i  out/in  NR_FU/NR_FU  per-FU dispatch handshake.
REQ-014 fu_tid_o, fu_op_a_o, fu_op_b_o  out  TID_W, DATA_W, DATA_W  head payload, shared by all FUs.
REQ-015 usage_o  out  CNT_W  occupied entries; full_o, empty_o  out  1 each.
REQ-016 bad_fu_o  out  1  pulse: head entry discarded for invalid FU index.
REQ-017 stall_issue_o  out  1  head valid, target FU not ready; stall_cnt_o  out  32  stall-cycle count.

Function
REQ-018 Storage SHALL be a circular buffer with read/write pointers wrapping modulo DEPTH and a CNT_W occupancy counter.
REQ-019 instr_ready_o SHALL equal !full_o && !flush_i (no same-cycle push-on-pop bypass when full).
REQ-020 Push SHALL occur when instr_valid_i && instr_ready_o; entry visible at head no earlier than next cycle (latency 1, no write-to-output bypass).
REQ-021 Dispatch SHALL be strictly in order, at most one entry per cycle, from the head only.
REQ-022 fu_valid_o[k] SHALL be 1 iff !empty_o && !flush_i && head.fu == k && k < NR_FU; all other bits 0 (one-hot or zero).
REQ-023 Pop SHALL occur when fu_valid_o[k] && fu_ready_i[k]; fu_*_o payload SHALL stay stable while fu_valid_o is held.
REQ-024 Head with fu >= NR_FU SHALL be popped without dispatch in one cycle with bad_fu_o=1 that cycle; no fu_valid_o bit asserted.
REQ-025 Simultaneous push and pop SHALL leave usage_o unchanged; pointers both advance.
REQ-026 flush_i SHALL, next cycle, set usage_o=0, pointers equal, empty_o=1; pushes and pops in the flush cycle SHALL be ignored.
REQ-027 stall_issue_o SHALL be 1 iff !empty_o && !flush_i && valid FU index && !fu_ready_i[head.fu].
REQ-028 stall_cnt_o SHALL increment by 1 each stall_issue_o cycle, saturate at 2^32-1, and not be cleared by flush_i.
REQ-029 full_o = (usage_o == DEPTH); empty_o = (usage_o == 0).

Reset
REQ-030 On rst_ni low, pointers, usage_o, stall_cnt_o SHALL be 0 immediately (asynchronous); fu_valid_o=0, bad_fu_o=0, stall_issue_o=0, empty_o=1, full_o=0, instr_ready_o=1 after release.
REQ-031 Reset asserted mid-operation SHALL drop all entries; payload storage need not be reset.

Verification
REQ-032 Push tid 1..4 to FU 2 with fu_ready_i=0 (DEPTH=4) -> full_o=1, instr_ready_o=0, fu_valid_o=4'b0100, stall_cnt_o increments every cycle.
REQ-033 Then raise fu_ready_i[2] for 4 cycles -> fu_tid_o sequence 1,2,3,4, usage_o 4->0, empty_o=1.
REQ-034 usage_o=2, concurrent push and pop -> usage_o stays 2; pointer wrap across entry 3->0 preserves order.
REQ-035 Head fu=7 (NR_FU=4) -> bad_fu_o pulse 1 cycle, fu_valid_o=0, next entry at head following cycle.
REQ-036 flush_i with usage_o=3 and instr_valid_i=1 -> next cycle usage_o=0, no dispatch, pushed entry lost, stall_cnt_o unchanged.
REQ-037 rst_ni low mid-dispatch with usage_o=2 -> usage_o=0, fu_valid_o=0, stall_cnt_o=0 without clock edge.

Source files
------------

// File: rtl/issue_queue_dispatch_if.sv
// Push and dispatch handshake bundle for issue_queue_dispatch.
// The slave modport is the queue side; the master modport is the front-end and FU side.
interface issue_queue_dispatch_if #(
    parameter int unsigned NR_FU    = 4,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned TID_W    = 3,
    parameter int unsigned FU_IDX_W = ($clog2(NR_FU) + 1 > 1) ? $clog2(NR_FU) + 1 : 1
);
    logic                instr_valid_i;
    logic                instr_ready_o;
    logic [FU_IDX_W-1:0] instr_fu_i;
    logic [TID_W-1:0]    instr_tid_i;
    logic [DATA_W-1:0]   instr_op_a_i;
    logic [DATA_W-1:0]   instr_op_b_i;
    logic [NR_FU-1:0]    fu_valid_o;
    logic [NR_FU-1:0]    fu_ready_i;
    logic [TID_W-1:0]    fu_tid_o;
    logic [DATA_W-1:0]   fu_op_a_o;
    logic [DATA_W-1:0]   fu_op_b_o;

    modport master (
        output instr_valid_i, instr_fu_i, instr_tid_i, instr_op_a_i, instr_op_b_i, fu_ready_i,
        input  instr_ready_o, fu_valid_o, fu_tid_o, fu_op_a_o, fu_op_b_o
    );

    modport slave (
        input  instr_valid_i, instr_fu_i, instr_tid_i, instr_op_a_i, instr_op_b_i, fu_ready_i,
        output instr_ready_o, fu_valid_o, fu_tid_o, fu_op_a_o, fu_op_b_o
    );
endinterface

// File: rtl/issue_queue_dispatch.sv
// In-order issue queue: circular buffer that dispatches its head entry to one of NR_FU units.
// Heads aimed at a nonexistent FU are dropped with a one-cycle bad_fu_o pulse.
module issue_queue_dispatch #(
    parameter int unsigned  DEPTH    = 4,
    parameter int unsigned  NR_FU    = 4,
    parameter int unsigned  DATA_W   = 64,
    parameter int unsigned  TID_W    = 3,
    localparam int unsigned FU_IDX_W = ($clog2(NR_FU) + 1 > 1) ? $clog2(NR_FU) + 1 : 1,
    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    issue_queue_dispatch_if.slave bus,
    output logic [CNT_W-1:0]      usage_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  bad_fu_o,
    output logic                  stall_issue_o,
    output logic [31:0]           stall_cnt_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CNT_W-1:0]    usage_q, usage_d;
    logic [31:0]         stall_cnt_q, stall_cnt_d;
    logic [FU_IDX_W-1:0] fu_mem_q  [DEPTH];
    logic [FU_IDX_W-1:0] fu_mem_d  [DEPTH];
    logic [TID_W-1:0]    tid_mem_q [DEPTH];
    logic [TID_W-1:0]    tid_mem_d [DEPTH];
    logic [DATA_W-1:0]   opa_mem_q [DEPTH];
    logic [DATA_W-1:0]   opa_mem_d [DEPTH];
    logic [DATA_W-1:0]   opb_mem_q [DEPTH];
    logic [DATA_W-1:0]   opb_mem_d [DEPTH];

    logic [FU_IDX_W-1:0] head_fu;
    logic [NR_FU-1:0]    fu_valid;
    logic                active, head_ok, head_rdy, instr_ready, push, pop;

    assign empty_o     = (usage_q == '0);
    assign full_o      = (usage_q == CNT_W'(DEPTH));
    assign instr_ready = !full_o && !flush_i;
    assign active      = !empty_o && !flush_i;
    assign head_fu     = fu_mem_q[rptr_q];
    assign head_ok     = (head_fu < FU_IDX_W'(NR_FU));

    // Decode the head's FU index once; head_rdy is only meaningful when head_ok.
    always_comb begin
        fu_valid = '0;
        head_rdy = 1'b0;
        for (int k = 0; k < NR_FU; k++) begin
            if (head_fu == FU_IDX_W'(k)) begin
                fu_valid[k] = active && head_ok;
                head_rdy    = bus.fu_ready_i[k];
            end
        end
    end

    assign bad_fu_o      = active && !head_ok;
    assign stall_issue_o = active && head_ok && !head_rdy;
    assign push          = bus.instr_valid_i && instr_ready;
    assign pop           = (|(fu_valid & bus.fu_ready_i)) || bad_fu_o;

    always_comb begin
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        usage_d     = usage_q;
        stall_cnt_d = stall_cnt_q;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            usage_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            usage_d = usage_q + CNT_W'(push) - CNT_W'(pop);
        end
        // The stall counter deliberately survives flushes and saturates instead of wrapping.
        if (stall_issue_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_comb begin
        fu_mem_d  = fu_mem_q;
        tid_mem_d = tid_mem_q;
        opa_mem_d = opa_mem_q;
        opb_mem_d = opb_mem_q;
        if (push) begin
            fu_mem_d[wptr_q]  = bus.instr_fu_i;
            tid_mem_d[wptr_q] = bus.instr_tid_i;
            opa_mem_d[wptr_q] = bus.instr_op_a_i;
            opb_mem_d[wptr_q] = bus.instr_op_b_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q      <= '0;
            wptr_q      <= '0;
            usage_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            usage_q     <= usage_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        fu_mem_q  <= fu_mem_d;
        tid_mem_q <= tid_mem_d;
        opa_mem_q <= opa_mem_d;
        opb_mem_q <= opb_mem_d;
    end

    assign bus.instr_ready_o = instr_ready;
    assign bus.fu_valid_o    = fu_valid;
    assign bus.fu_tid_o      = tid_mem_q[rptr_q];
    assign bus.fu_op_a_o     = opa_mem_q[rptr_q];
    assign bus.fu_op_b_o     = opb_mem_q[rptr_q];
    assign usage_o           = usage_q;
    assign stall_cnt_o       = stall_cnt_q;
endmodule

// File: tb/tb_issue_queue_dispatch.sv
// Randomised and directed bench for issue_queue_dispatch against a queue-based reference model.
module tb_issue_queue_dispatch;
    localparam int unsigned DEPTH = 4, NR_FU = 4, DATA_W = 64, TID_W = 3, FU_IDX_W = 3, CNT_W = 3;

    typedef struct {
        logic [FU_IDX_W-1:0] fu;
        logic [TID_W-1:0]    tid;
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
    } entry_t;

    logic clk = 1'b0, rst_ni = 1'b0, flush = 1'b0;
    logic [CNT_W-1:0] usage;
    logic full, empty, bad_fu, stall_issue;
    logic [31:0] stall_cnt;
    int errors = 0, checks = 0;

    entry_t mq[$];
    longint stall_model = 0;
    logic [CNT_W-1:0]  exp_usage;
    logic              exp_empty, exp_full, exp_ready, exp_bad, exp_stall;
    logic [NR_FU-1:0]  exp_valid;
    logic [TID_W-1:0]  exp_tid;
    logic [DATA_W-1:0] exp_a, exp_b;

    issue_queue_dispatch_if #(.NR_FU(NR_FU), .DATA_W(DATA_W), .TID_W(TID_W), .FU_IDX_W(FU_IDX_W)) bus ();

    issue_queue_dispatch #(.DEPTH(DEPTH), .NR_FU(NR_FU), .DATA_W(DATA_W), .TID_W(TID_W)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .bus(bus),
        .usage_o(usage), .full_o(full), .empty_o(empty), .bad_fu_o(bad_fu),
        .stall_issue_o(stall_issue), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected outputs for the current cycle from the model queue and the driven inputs.
    function automatic void predict();
        entry_t h;
        exp_usage = CNT_W'(mq.size());
        exp_empty = (mq.size() == 0);
        exp_full  = (mq.size() == DEPTH);
        exp_ready = !exp_full && !flush;
        exp_valid = '0; exp_bad = 1'b0; exp_stall = 1'b0;
        exp_tid = '0; exp_a = '0; exp_b = '0;
        if (!exp_empty && !flush) begin
            h = mq[0];
            exp_tid = h.tid; exp_a = h.a; exp_b = h.b;
            if (h.fu < NR_FU) begin
                exp_valid[h.fu] = 1'b1;
                exp_stall = !bus.fu_ready_i[h.fu];
            end else begin
                exp_bad = 1'b1;
            end
        end
    endfunction

    task automatic tick();
        logic do_pop, do_push;
        predict();
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            do_pop  = ((exp_valid & bus.fu_ready_i) != '0) || exp_bad;
            do_push = bus.instr_valid_i && exp_ready;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{fu: bus.instr_fu_i, tid: bus.instr_tid_i,
                                        a: bus.instr_op_a_i, b: bus.instr_op_b_i});
        end
        if (exp_stall && stall_model != 64'hFFFF_FFFF) stall_model++;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] fu, input logic [2:0] tid,
                         input logic [3:0] rdy, input logic fl);
        bus.instr_valid_i = v;
        bus.instr_fu_i    = fu;
        bus.instr_tid_i   = tid;
        bus.instr_op_a_i  = {$urandom, $urandom};
        bus.instr_op_b_i  = {$urandom, $urandom};
        bus.fu_ready_i    = rdy;
        flush             = fl;
        #1;
        predict();
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 4'b0000, 0);
        checks++; if (usage !== 3'd0) begin errors++; $display("[TB] FAIL rst_usage: got %0d want 0", usage); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("[TB] FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL rst_empty: got %b want 1", empty); end
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        checks++; if (bus.instr_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready: got %b want 1", bus.instr_ready_o); end
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL rst_full: got %b want 0", full); end
        checks++; if ({bus.fu_valid_o, bad_fu, stall_issue} !== 6'b0) begin errors++;
            $display("[TB] FAIL rst_outputs: got %b want 000000", {bus.fu_valid_o, bad_fu, stall_issue}); end
    endtask

    task automatic test_fill_stall();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 2, 3'(i), 4'b0000, 0);
            checks++; if (bus.instr_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL fill_ready: got %b want 1", bus.instr_ready_o); end
            checks++; if (stall_cnt !== stall_model[31:0]) begin errors++; $display("[TB] FAIL fill_stall_cnt: got %0d want %0d", stall_cnt, stall_model); end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 2, 3'd7, 4'b0000, 0);
            checks++; if (full !== 1'b1 || usage !== 3'd4) begin errors++; $display("[TB] FAIL full: got full=%b usage=%0d want 1/4", full, usage); end
            checks++; if (bus.instr_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b want 0", bus.instr_ready_o); end
            checks++; if (bus.fu_valid_o !== 4'b0100 || stall_issue !== 1'b1) begin errors++;
                $display("[TB] FAIL full_valid: got %b/%b want 0100/1", bus.fu_valid_o, stall_issue); end
            checks++; if (stall_cnt !== 32'(3 + i)) begin errors++; $display("[TB] FAIL stall_count: got %0d want %0d", stall_cnt, 3 + i); end
            tick();
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 4'b0100, 0);
            checks++; if (bus.fu_tid_o !== 3'(i) || bus.fu_valid_o !== 4'b0100) begin errors++;
                $display("[TB] FAIL drain_tid: got %0d/%b want %0d/0100", bus.fu_tid_o, bus.fu_valid_o, i); end
            checks++; if (usage !== 3'(5 - i)) begin errors++; $display("[TB] FAIL drain_usage: got %0d want %0d", usage, 5 - i); end
            tick();
        end
        drive(0, 0, 0, 4'b0000, 0);
        checks++; if (usage !== 3'd0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_empty: got %0d/%b want 0/1", usage, empty); end
    endtask

    task automatic test_wrap();
        drive(1, 1, 5, 4'b0000, 0); tick();
        drive(1, 1, 6, 4'b0000, 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 3'(i), 4'b0010, 0);
            checks++; if (usage !== 3'd2) begin errors++; $display("[TB] FAIL wrap_usage: got %0d want 2", usage); end
            checks++; if (bus.fu_tid_o !== exp_tid || bus.fu_op_a_o !== exp_a) begin errors++;
                $display("[TB] FAIL wrap_order: got %0d want %0d", bus.fu_tid_o, exp_tid); end
            tick();
        end
        for (int i = 2; i <= 3; i++) begin
            drive(0, 0, 0, 4'b0010, 0);
            checks++; if (bus.fu_tid_o !== 3'(i)) begin errors++; $display("[TB] FAIL wrap_tail: got %0d want %0d", bus.fu_tid_o, i); end
            tick();
        end
    endtask

    task automatic test_bad_fu();
        drive(1, 7, 2, 4'b0000, 0); tick();
        drive(1, 1, 3, 4'b0000, 0);
        checks++; if (bad_fu !== 1'b1 || bus.fu_valid_o !== 4'b0000) begin errors++;
            $display("[TB] FAIL bad_fu: got %b/%b want 1/0000", bad_fu, bus.fu_valid_o); end
        tick();
        drive(0, 0, 0, 4'b0000, 0);
        checks++; if (bad_fu !== 1'b0 || bus.fu_valid_o !== 4'b0010 || bus.fu_tid_o !== 3'd3) begin errors++;
            $display("[TB] FAIL bad_fu_next: got %b/%b/%0d want 0/0010/3", bad_fu, bus.fu_valid_o, bus.fu_tid_o); end
        tick();
        drive(0, 0, 0, 4'b0010, 0); tick();
    endtask

    task automatic test_flush();
        longint cnt_before;
        for (int i = 0; i < 3; i++) begin drive(1, 0, 3'(i), 4'b0000, 0); tick(); end
        drive(1, 3, 5, 4'b1111, 1);
        checks++; if (usage !== 3'd3) begin errors++; $display("[TB] FAIL flush_pre_usage: got %0d want 3", usage); end
        checks++; if (bus.fu_valid_o !== 4'b0000 || stall_issue !== 1'b0 || bus.instr_ready_o !== 1'b0) begin errors++;
            $display("[TB] FAIL flush_cycle: got %b/%b/%b want 0000/0/0", bus.fu_valid_o, stall_issue, bus.instr_ready_o); end
        cnt_before = stall_model;
        tick();
        drive(0, 0, 0, 4'b1111, 0);
        checks++; if (usage !== 3'd0 || empty !== 1'b1 || bus.fu_valid_o !== 4'b0000) begin errors++;
            $display("[TB] FAIL flush_after: got %0d/%b/%b want 0/1/0000", usage, empty, bus.fu_valid_o); end
        checks++; if (stall_cnt !== cnt_before[31:0]) begin errors++; $display("[TB] FAIL flush_stall_cnt: got %0d want %0d", stall_cnt, cnt_before); end
    endtask

    task automatic test_async_reset();
        drive(1, 3, 1, 4'b0000, 0); tick();
        drive(1, 3, 2, 4'b0000, 0); tick();
        drive(0, 0, 0, 4'b1000, 0);
        checks++; if (usage !== 3'd2 || bus.fu_valid_o !== 4'b1000) begin errors++;
            $display("[TB] FAIL areset_pre: got %0d/%b want 2/1000", usage, bus.fu_valid_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        mq.delete(); stall_model = 0;
        checks++; if (usage !== 3'd0 || bus.fu_valid_o !== 4'b0000 || stall_cnt !== 32'd0) begin errors++;
            $display("[TB] FAIL areset: got %0d/%b/%0d want 0/0000/0", usage, bus.fu_valid_o, stall_cnt); end
        bus.fu_ready_i = 4'b0000;
        @(negedge clk);
        rst_ni = 1'b1;
        drive(0, 0, 0, 4'b0000, 0);
        checks++; if (empty !== 1'b1 || bus.instr_ready_o !== 1'b1) begin errors++;
            $display("[TB] FAIL areset_release: got %b/%b want 1/1", empty, bus.instr_ready_o); end
    endtask

    task automatic test_random();
        logic [2:0] fu;
        for (int n = 0; n < 400; n++) begin
            fu = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            drive(1'($urandom_range(0, 1)), fu, 3'($urandom), 4'($urandom), ($urandom_range(0, 24) == 0));
            checks++; if (usage !== exp_usage || empty !== exp_empty || full !== exp_full) begin errors++;
                $display("[TB] FAIL rnd_occupancy: got %0d/%b/%b want %0d/%b/%b", usage, empty, full, exp_usage, exp_empty, exp_full); end
            checks++; if (bus.instr_ready_o !== exp_ready) begin errors++; $display("[TB] FAIL rnd_ready: got %b want %b", bus.instr_ready_o, exp_ready); end
            checks++; if (bus.fu_valid_o !== exp_valid || bad_fu !== exp_bad || stall_issue !== exp_stall) begin errors++;
                $display("[TB] FAIL rnd_dispatch: got %b/%b/%b want %b/%b/%b", bus.fu_valid_o, bad_fu, stall_issue, exp_valid, exp_bad, exp_stall); end
            checks++; if (stall_cnt !== stall_model[31:0]) begin errors++; $display("[TB] FAIL rnd_stall_cnt: got %0d want %0d", stall_cnt, stall_model); end
            if (exp_valid != '0) begin
                checks++; if (bus.fu_tid_o !== exp_tid || bus.fu_op_a_o !== exp_a || bus.fu_op_b_o !== exp_b) begin errors++;
                    $display("[TB] FAIL rnd_payload: got tid %0d a %h want tid %0d a %h", bus.fu_tid_o, bus.fu_op_a_o, exp_tid, exp_a); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_drain();
        test_wrap();
        test_bad_fu();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
